// File: rtl/pc_sequencer_if.sv
// Fetch/issue handshake bundle between the PC sequencer, instruction memory and the decode consumer.
// master drives the sequencer inputs; slave is the sequencer itself.
interface pc_sequencer_if;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign_trap;

    modport master (
        output pc_write, redirect_valid, redirect_target, imem_ack,
        input  imem_req, imem_addr, pc_out, pc_plus4, instr_valid, misalign_trap
    );

    modport slave (
        input  pc_write, redirect_valid, redirect_target, imem_ack,
        output imem_req, imem_addr, pc_out, pc_plus4, instr_valid, misalign_trap
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT -> FETCH (hold imem_req until imem_ack) -> ISSUE (hold until pc_write).
// One cycle ack-to-instr_valid; ISSUE stalls on pc_write, FETCH stalls on imem_ack.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        pend_q;
    logic [31:0] pend_tgt_q;
    logic        req_q;
    logic        ivld_q;
    logic        trap_q;
    logic [31:0] fetch_tgt;
    logic [31:0] pc_plus4;

    // Misaligned targets vector to the trap handler instead of being fetched.
    function automatic logic [31:0] land(input logic [31:0] tgt);
        return (tgt[1:0] != 2'b00) ? TRAP_VEC : tgt;
    endfunction

    // A redirect presented alongside the ack beats the older pending one.
    always_comb begin
        fetch_tgt = pend_tgt_q;
        if (bus.redirect_valid) begin
            fetch_tgt = bus.redirect_target;
        end
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            req_q      <= 1'b0;
            ivld_q     <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            trap_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect_valid || pend_q) begin
                            // Returned word is stale: refetch at the target.
                            pc_q   <= land(fetch_tgt);
                            trap_q <= (fetch_tgt[1:0] != 2'b00);
                            pend_q <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                            req_q   <= 1'b0;
                            ivld_q  <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_q     <= 1'b1;
                        pend_tgt_q <= bus.redirect_target;
                    end
                end
                ISSUE: begin
                    if (bus.pc_write) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        ivld_q  <= 1'b0;
                        if (bus.redirect_valid) begin
                            pc_q   <= land(bus.redirect_target);
                            trap_q <= (bus.redirect_target[1:0] != 2'b00);
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                    ivld_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req      = req_q;
    assign bus.imem_addr     = pc_q;
    assign bus.pc_out        = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.instr_valid   = ivld_q;
    assign bus.misalign_trap = trap_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: where the sequencer is in its fetch/issue life cycle.
    bit          m_booting;
    bit          m_have_word;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_trap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_booting   = 1'b1;
        m_have_word = 1'b0;
        m_pc        = RESET_PC;
        m_pend.delete();
        m_trap      = 1'b0;
    endtask

    task automatic model_jump(input logic [31:0] t);
        if (t % 4 != 0) begin
            m_pc   = TRAP_VEC;
            m_trap = 1'b1;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic model_edge();
        m_trap = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_have_word) begin
            if (bus.imem_ack) begin
                if (bus.redirect_valid) begin
                    model_jump(bus.redirect_target);
                    m_pend.delete();
                end else if (m_pend.size() > 0) begin
                    model_jump(m_pend[$]);
                    m_pend.delete();
                end else begin
                    m_have_word = 1'b1;
                end
            end else if (bus.redirect_valid) begin
                m_pend.push_back(bus.redirect_target);
            end
        end else if (bus.pc_write) begin
            m_have_word = 1'b0;
            if (bus.redirect_valid) model_jump(bus.redirect_target);
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        bit fetching;
        fetching = !m_booting && !m_have_word;
        chk({tag, ".req"},  {31'b0, bus.imem_req},      {31'b0, fetching});
        chk({tag, ".iv"},   {31'b0, bus.instr_valid},   {31'b0, m_have_word});
        chk({tag, ".pc"},   bus.pc_out,                 m_pc);
        chk({tag, ".addr"}, bus.imem_addr,              m_pc);
        chk({tag, ".p4"},   bus.pc_plus4,               m_pc + 32'd4);
        chk({tag, ".trap"}, {31'b0, bus.misalign_trap}, {31'b0, m_trap});
    endtask

    task automatic tick(input string tag);
        if (reset) model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit ack, input bit pw, input bit rv, input logic [31:0] tgt);
        bus.imem_ack        = ack;
        bus.pc_write        = pw;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
    endtask

    // Steps forward with ack and pc_write until the DUT issues the word at pc.
    task automatic go_issue_at(input logic [31:0] pc);
        for (int i = 0; i < 100; i++) begin
            if (!m_booting && m_have_word && m_pc == pc) break;
            drive(1'b1, m_have_word, 1'b0, 32'h0);
            tick("walk");
        end
        chk("reach.iv", {31'b0, bus.instr_valid}, 32'd1);
        chk("reach.pc", bus.pc_out, pc);
    endtask

    logic [31:0] addrs[$];
    logic [31:0] rt;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Free-running fetch/issue right after reset release.
        reset = 1'b1;
        #1;
        check_all("boot");
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tick("run");
            if (i == 0) chk("first_req", {31'b0, bus.imem_req}, 32'd1);
            if (bus.imem_req && (addrs.size() == 0 || addrs[$] != bus.imem_addr))
                addrs.push_back(bus.imem_addr);
        end
        chk("seq0", addrs[0], 32'h0);
        chk("seq1", addrs[1], 32'h4);
        chk("seq2", addrs[2], 32'h8);

        // Taken branch from ISSUE.
        go_issue_at(32'h10);
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        tick("br");
        chk("br.addr", bus.imem_addr, 32'h40);
        chk("br.trap", {31'b0, bus.misalign_trap}, 32'd0);

        // Redirect while fetching at 0x20, ack arrives three cycles later.
        go_issue_at(32'h40);
        drive(1'b0, 1'b1, 1'b1, 32'h20);
        tick("to20");
        drive(1'b0, 1'b0, 1'b1, 32'h80);
        tick("pend");
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick("pend_w1");
        tick("pend_w2");
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick("pend_ack");
        chk("pend.iv", {31'b0, bus.instr_valid}, 32'd0);
        chk("pend.addr", bus.imem_addr, 32'h80);

        // Misaligned redirect traps for exactly one cycle.
        drive(1'b1, 1'b0, 1'b1, 32'h42);
        tick("mis");
        chk("mis.pc", bus.pc_out, 32'h100);
        chk("mis.trap", {31'b0, bus.misalign_trap}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("mis_after");
        chk("mis.trap_off", {31'b0, bus.misalign_trap}, 32'd0);

        // Wraparound at the top of the address space.
        go_issue_at(32'h100);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick("to_top");
        go_issue_at(32'hFFFF_FFFC);
        chk("top.p4", bus.pc_plus4, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick("wrap");
        chk("wrap.pc", bus.pc_out, 32'h0);
        chk("wrap.trap", {31'b0, bus.misalign_trap}, 32'd0);

        // Random traffic, including stray pc_write/redirects and misaligned targets.
        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, rt);
            tick("rand");
        end

        // Asynchronous reset while a fetch is outstanding.
        for (int i = 0; i < 50; i++) begin
            if (!m_booting && !m_have_word) break;
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tick("to_fetch");
        end
        chk("pre_rst.req", {31'b0, bus.imem_req}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst.req", {31'b0, bus.imem_req}, 32'd0);
        chk("arst.pc", bus.pc_out, RESET_PC);
        chk("arst.iv", {31'b0, bus.instr_valid}, 32'd0);
        tick("in_rst");
        reset = 1'b1;
        #1;
        check_all("reboot");
        for (int i = 0; i < 4; i++) tick("reboot_run");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
